// File: rtl/vend_dispense_arbiter_if.sv
// ---------------------------------------------------------------------------
// vend_dispense_arbiter_if
// Bundle between the per-channel credit FSMs / motor driver (master side)
// and the dispense arbiter (slave side).
//
//   req       NUM_REQ  level request per channel, held until done or withdraw
//   abort     1        abort the vend in progress
//   jam       1        motor jam sensor
//   grant     NUM_REQ  one-hot grant, zero when idle
//   motor_on  1        motor drive
//   done      NUM_REQ  one-cycle completion pulse to the served channel
//   busy      1        arbiter not idle
//   fault     1        sticky jam indication
//   vend_count 16      completed vends (only with VEND_COUNT_EN)
// ---------------------------------------------------------------------------
interface vend_dispense_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic               abort;
  logic               jam;
  logic [NUM_REQ-1:0] grant;
  logic               motor_on;
  logic [NUM_REQ-1:0] done;
  logic               busy;
  logic               fault;
`ifdef VEND_COUNT_EN
  logic [15:0]        vend_count;
`endif

  modport master (
    output req, abort, jam,
`ifdef VEND_COUNT_EN
    input  vend_count,
`endif
    input  grant, motor_on, done, busy, fault
  );

  modport slave (
    input  req, abort, jam,
`ifdef VEND_COUNT_EN
    output vend_count,
`endif
    output grant, motor_on, done, busy, fault
  );
endinterface

// File: rtl/vend_dispense_arbiter.sv
// ---------------------------------------------------------------------------
// vend_dispense_arbiter
// Round-robin arbiter/sequencer sharing one dispense motor between NUM_REQ
// vending channels. A granted channel gets the motor for DISPENSE_CYCLES
// cycles, a one-cycle done pulse, then a GAP_CYCLES cooldown. A jam during
// the motor run parks the block in a sticky FAULT until reset.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   arb   vend_dispense_arbiter_if.slave (req/abort/jam in,
//         grant/motor_on/done/busy/fault out)
//
// Optional feature macro: VEND_COUNT_EN -- adds arb.vend_count, a saturating
// 16-bit count of completed vends.
//
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------

// Per-channel output decode: one instance per channel.
module vend_lane_dec #(
  parameter int IW   = 2,
  parameter int LANE = 0
) (
  input  logic [IW-1:0] i_win,
  input  logic          i_grant_en,
  input  logic          i_done_en,
  output logic          o_grant,
  output logic          o_done
);
  logic w_hit;
  assign w_hit   = (i_win == IW'(LANE));
  assign o_grant = i_grant_en & w_hit;
  assign o_done  = i_done_en  & w_hit;
endmodule

module vend_dispense_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int DISPENSE_CYCLES = 8,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  vend_dispense_arbiter_if.slave arb
);

  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CMAX = (DISPENSE_CYCLES > GAP_CYCLES) ? DISPENSE_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;

  localparam logic [CW-1:0] RUN_LOAD = CW'(DISPENSE_CYCLES - 1);
  // GAP_CYCLES==0 never enters GAP, so the load value is then irrelevant.
  localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit            HAS_GAP  = (GAP_CYCLES > 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic [2:0]    r_state;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_win;
  logic [CW-1:0] r_cnt;

  logic [IW-1:0] w_pick;
  logic          w_any;
  logic          w_grant_en;
  logic          w_done_en;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_done;

  // Channel index at rotation offset off from the last winner, with wrap.
  // Offsets stay below NUM_REQ, so one conditional subtract covers the wrap.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] last, input int off);
    int s;
    s = int'(last) + 1 + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // Walk offsets from farthest to nearest so the nearest requester after
  // r_last is the final (winning) assignment.
  always_comb begin
    w_pick = r_last;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (arb.req[rr_idx(r_last, i)]) w_pick = rr_idx(r_last, i);
    end
  end
  assign w_any = |arb.req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= IW'(NUM_REQ - 1);
      r_win   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win   <= w_pick;
            r_last  <= w_pick;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!arb.req[r_win]) begin
            r_state <= S_IDLE;
          end else if (arb.abort) begin
            r_state <= HAS_GAP ? S_GAP : S_IDLE;
            r_cnt   <= GAP_LOAD;
          end else begin
            r_state <= S_RUN;
            r_cnt   <= RUN_LOAD;
          end
        end
        S_RUN: begin
          // jam outranks abort, abort outranks normal expiry; req is ignored.
          if (arb.jam) begin
            r_state <= S_FAULT;
          end else if (arb.abort) begin
            r_state <= HAS_GAP ? S_GAP : S_IDLE;
            r_cnt   <= GAP_LOAD;
          end else if (r_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= HAS_GAP ? S_GAP : S_IDLE;
          r_cnt   <= GAP_LOAD;
        end
        S_GAP: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_grant_en = (r_state == S_GRANT) || (r_state == S_RUN) || (r_state == S_DONE);
  assign w_done_en  = (r_state == S_DONE);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    vend_lane_dec #(.IW(IW), .LANE(g)) u_dec (
      .i_win      (r_win),
      .i_grant_en (w_grant_en),
      .i_done_en  (w_done_en),
      .o_grant    (w_grant[g]),
      .o_done     (w_done[g])
    );
  end

  assign arb.grant    = w_grant;
  assign arb.done     = w_done;
  assign arb.motor_on = (r_state == S_RUN);
  assign arb.busy     = (r_state != S_IDLE);
  assign arb.fault    = (r_state == S_FAULT);

`ifdef VEND_COUNT_EN
  logic [15:0] r_vend_count;
  // Only the DONE state counts, so aborted/withdrawn/faulted vends never do.
  always_ff @(posedge clk) begin
    if (rst)                                         r_vend_count <= '0;
    else if (r_state == S_DONE && r_vend_count != 16'hFFFF) r_vend_count <= r_vend_count + 16'd1;
  end
  assign arb.vend_count = r_vend_count;
`endif

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
module tb_vend_dispense_arbiter;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  vend_dispense_arbiter_if #(.NUM_REQ(4)) bus ();

  vend_dispense_arbiter #(.NUM_REQ(4), .DISPENSE_CYCLES(8), .GAP_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; bus.req = '0; bus.abort = 0; bus.jam = 0;
    tick();
    rst = 0;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Follow one vend from the current sample up to and including its done
  // pulse, then advance one cycle past it.
  task automatic serve(input logic drop, output int ch, output int mcyc,
                       output int gcyc, output logic [3:0] dn);
    logic got;
    got = 0; ch = -1; mcyc = 0; gcyc = 0; dn = '0;
    for (int t = 0; t < 60 && !got; t++) begin
      if (bus.grant != 0) begin
        gcyc++;
        if (ch < 0) ch = oh_idx(bus.grant);
      end
      if (bus.motor_on) mcyc++;
      if (bus.done != 0) begin
        dn  = bus.done;
        got = 1;
        if (drop) bus.req = bus.req & ~bus.done;
      end
      tick();
    end
    if (!got) chk("serve_timeout", 32'd0, 32'd1);
  endtask

  int ch, mc, gc;
  logic [3:0] dn;
  logic any_m, any_d;

  initial begin
    clk = 0; rst = 1; bus.req = '0; bus.abort = 0; bus.jam = 0;
    tick(); tick();
    chk("rst_grant", bus.grant, 0);
    chk("rst_motor", bus.motor_on, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_fault", bus.fault, 0);
`ifdef VEND_COUNT_EN
    chk("rst_count", bus.vend_count, 0);
`endif
    rst = 0;

    // single vend on channel 2
    do_reset();
    bus.req = 4'b0100;
    tick();
    chk("sv_grant0", bus.grant, 4'b0100);
    chk("sv_motor0", bus.motor_on, 0);
    serve(1, ch, mc, gc, dn);
    chk("sv_ch",    ch, 2);
    chk("sv_motor", mc, 8);
    chk("sv_gcyc",  gc, 10);
    chk("sv_done",  dn, 4'b0100);
    chk("sv_gap1_busy", bus.busy, 1);
    chk("sv_gap1_grant", bus.grant, 0);
    tick();
    chk("sv_gap2_busy", bus.busy, 1);
    tick();
    chk("sv_idle_busy", bus.busy, 0);
`ifdef VEND_COUNT_EN
    chk("sv_count", bus.vend_count, 1);
`endif

    // round robin, each channel drops after service
    do_reset();
    bus.req = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      serve(1, ch, mc, gc, dn);
      chk($sformatf("rr_drop_ch%0d", s), ch, s);
      chk($sformatf("rr_drop_m%0d", s), mc, 8);
    end

    // round robin, requests held: must wrap back to 0
    do_reset();
    bus.req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      serve(0, ch, mc, gc, dn);
      chk($sformatf("rr_hold_ch%0d", s), ch, s % 4);
    end
`ifdef VEND_COUNT_EN
    chk("rr_count", bus.vend_count, 5);
`endif

    // withdraw during GRANT
    do_reset();
    bus.req = 4'b0010;
    tick();
    chk("wg_grant", bus.grant, 4'b0010);
    bus.req = '0;
    tick();
    chk("wg_grant_clr", bus.grant, 0);
    chk("wg_busy", bus.busy, 0);
    any_m = 0; any_d = 0;
    for (int t = 0; t < 12; t++) begin
      any_m |= bus.motor_on; any_d |= |bus.done;
      tick();
    end
    chk("wg_no_motor", any_m, 0);
    chk("wg_no_done",  any_d, 0);

    // withdraw during RUN: vend completes regardless
    do_reset();
    bus.req = 4'b0010;
    tick(); tick();
    chk("wr_motor", bus.motor_on, 1);
    bus.req = '0;
    serve(0, ch, mc, gc, dn);
    chk("wr_ch", ch, 1);
    chk("wr_motor_cyc", mc, 8);
    chk("wr_done", dn, 4'b0010);

    // abort on 3rd RUN cycle
    do_reset();
    bus.req = 4'b0101;
    tick();
    chk("ab_grant", bus.grant, 4'b0001);
    tick(); tick(); tick();
    bus.abort = 1;
    tick();
    bus.abort = 0;
    chk("ab_motor", bus.motor_on, 0);
    chk("ab_done",  bus.done, 0);
    chk("ab_grant_gap", bus.grant, 0);
    chk("ab_busy1", bus.busy, 1);
    tick();
    chk("ab_busy2", bus.busy, 1);
    tick();
    chk("ab_idle", bus.busy, 0);
    tick();
    chk("ab_next", bus.grant, 4'b0100);
`ifdef VEND_COUNT_EN
    chk("ab_count", bus.vend_count, 0);
`endif

    // jam together with abort
    do_reset();
    bus.req = 4'b1111;
    tick(); tick();
    bus.jam = 1; bus.abort = 1;
    tick();
    bus.jam = 0; bus.abort = 0;
    chk("jm_fault", bus.fault, 1);
    chk("jm_grant", bus.grant, 0);
    chk("jm_motor", bus.motor_on, 0);
    repeat (5) tick();
    chk("jm_sticky", bus.fault, 1);
    chk("jm_sticky_grant", bus.grant, 0);
    chk("jm_busy", bus.busy, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("jm_rst_fault", bus.fault, 0);
    chk("jm_rst_busy", bus.busy, 0);
    tick();
    chk("jm_rst_last", bus.grant, 4'b0001);

    // reset on the 4th motor cycle
    do_reset();
    bus.req = 4'b1111;
    tick(); tick(); tick(); tick(); tick();
    chk("rr_run_motor", bus.motor_on, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("mr_grant", bus.grant, 0);
    chk("mr_motor", bus.motor_on, 0);
    chk("mr_busy",  bus.busy, 0);
    chk("mr_done",  bus.done, 0);
    tick();
    chk("mr_ch0", bus.grant, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vend_dispense_arbiter.md
Name: vend_dispense_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one dispense motor between NUM_REQ vending channels.
- Each channel's controller raises a request once credit is complete. The arbiter grants one channel, runs the motor for a fixed time, pulses done to the winner, then enforces a cooldown gap.
- A jam sensor forces a sticky fault state.
- Sits between the per-channel coin/credit FSMs and the motor driver.

Parameters:
- NUM_REQ, 4, number of requesting channels (2..8).
- DISPENSE_CYCLES, 8, motor-on duration in clk cycles (>=1).
- GAP_CYCLES, 2, cooldown cycles after each vend (>=0; 0 means no gap).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  NUM_REQ  per-channel level request; held high until done or the channel withdraws.
- abort  input  1  global abort of the vend in progress.
- jam  input  1  motor jam sensor, active-high.
- grant  output  NUM_REQ  one-hot grant to the serviced channel, zero when none.
- motor_on  output  1  motor drive.
- done  output  NUM_REQ  one-cycle pulse to the served channel on vend completion.
- busy  output  1  high in any state other than IDLE.
- fault  output  1  sticky jam indication.

Behaviour:
- Interface timing:
  - One clock; reset is synchronous and active-high.
  - All outputs are registered or decoded directly from registered state; there is no combinational input-to-output path.
- Reset values:
  - state=IDLE; grant=0; motor_on=0; done=0; busy=0; fault=0.
  - Round-robin pointer last=NUM_REQ-1, so channel 0 has highest priority first.
  - Cycle counter=0.
- States: IDLE, GRANT, RUN, DONE, GAP, FAULT.
- IDLE:
  - If req!=0 at an edge, select the first set bit searching from (last+1) mod NUM_REQ upward with wrap-around.
  - Latch the winner index, set last=winner, go to GRANT. grant is high from that edge.
- GRANT (1 cycle):
  - Winner's req low -> IDLE, grant cleared, no motor, no done.
  - abort -> GAP.
  - Otherwise -> RUN, counter loaded with DISPENSE_CYCLES-1.
- RUN:
  - motor_on=1; counter decrements each cycle.
  - At counter==0 -> DONE, so motor_on is high for exactly DISPENSE_CYCLES cycles.
  - Withdrawal of req is ignored in RUN.
  - abort -> GAP next edge, motor off, no done.
  - jam -> FAULT next edge. jam has priority over abort and over the counter expiring.
- DONE (1 cycle):
  - done[winner]=1, grant still high.
  - -> GAP with counter=GAP_CYCLES-1, or -> IDLE if GAP_CYCLES==0.
- GAP:
  - grant=0; motor off; requests are not serviced.
  - At counter==0 -> IDLE.
- FAULT:
  - grant=0; motor_on=0; fault=1.
  - Stays in FAULT until rst; all requests are ignored.
- Latency: req high at edge k (in IDLE) gives:
  - grant high from edge k;
  - motor_on high from edge k+1 through edge k+DISPENSE_CYCLES;
  - done pulse in the cycle after edge k+1+DISPENSE_CYCLES.
- Fairness:
  - A channel still requesting after being served ranks last next round.
  - No channel waits more than NUM_REQ-1 vends.
- Simultaneous events:
  - rst overrides everything.
  - In RUN: jam > abort > counter expiry.
  - New requests arriving during GRANT..GAP are held by the requesters and arbitrated only on return to IDLE.
- Counter width is clog2(max(DISPENSE_CYCLES,GAP_CYCLES)+1); it never wraps.
- Invariants: grant is always one-hot or zero; done is never asserted without the matching grant bit.

Optional Feature:
- Macro: VEND_COUNT_EN.
- Defined:
  - Adds output vend_count [15:0], reset 0.
  - Increments by 1 in each DONE cycle and saturates at 16'hFFFF.
  - Aborted, withdrawn or faulted vends are not counted.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single vend (NUM_REQ=4, DISPENSE_CYCLES=8, GAP_CYCLES=2): req=4'b0100 -> grant=0100 for 10 cycles; motor_on high 8 cycles; done=0100 for 1 cycle; busy low 2 cycles after done; with VEND_COUNT_EN, vend_count=1.
- Round-robin: req=4'b1111 held, each served channel's req dropped after its done -> service order 0,1,2,3. With req re-raised after service -> order continues 0,1,2,3,0 with no starvation.
- Withdraw: req[1] dropped during GRANT -> back to IDLE, motor_on never rises, done=0. Withdraw during RUN -> full 8 motor cycles and done[1] still pulses.
- Abort: abort on the 3rd RUN cycle -> motor_on low on the next edge, no done, GAP for 2 cycles, then the next pending request is granted; vend_count unchanged.
- Jam: jam and abort together on a RUN cycle -> FAULT. fault=1, grant=0, motor_on=0, and the state persists with req=1111; synchronous rst returns all outputs to 0 and last to 3.
- Reset mid-RUN: rst asserted on the 4th motor cycle -> on the next edge all outputs are 0 and state is IDLE; after release, channel 0 wins when req=1111.
